// File: rtl/clk_freq_meter_if.sv
// Host-side bundle for clk_freq_meter: enable, measured
// signal, windowed edge count results and period result.
interface clk_freq_meter_if #(
  parameter int CNT_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 16
);
  logic                    EN;
  logic                    SIG_IN;
  logic [CNT_WIDTH-1:0]    FREQ_COUNT;
  logic                    VALID;
  logic                    IN_RANGE;
  logic                    CLK_LOST;
  logic [PERIOD_WIDTH-1:0] PERIOD;
  logic                    PERIOD_VALID;

  modport master (
    output EN,
    output SIG_IN,
    input  FREQ_COUNT,
    input  VALID,
    input  IN_RANGE,
    input  CLK_LOST,
    input  PERIOD,
    input  PERIOD_VALID
  );

  modport slave (
    input  EN,
    input  SIG_IN,
    output FREQ_COUNT,
    output VALID,
    output IN_RANGE,
    output CLK_LOST,
    output PERIOD,
    output PERIOD_VALID
  );
endinterface

// File: rtl/clk_freq_meter.sv
// Gated edge counter and edge-to-edge period meter for a slow
// asynchronous clock, referenced to CLK_IN.
module clk_freq_meter #(
  parameter int GATE_CYCLES  = 100000,
  parameter int CNT_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 16,
  parameter int EXP_MIN      = 0,
  parameter int EXP_MAX      = 65535
) (
  input  logic            CLK_IN,
  input  logic            RST_N,
  clk_freq_meter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ARM, MEASURE, REPORT
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_WIDTH-1:0] PER_MAX = '1;
  localparam logic [31:0] GATE_LAST =
    32'(GATE_CYCLES - 1);

  state_e state_q, state_d;
  logic   s1_q, s2_q, s3_q, edge_q;
  logic [31:0] gate_q, gate_d;
  logic [CNT_WIDTH-1:0] ecnt_q, ecnt_d;
  logic [CNT_WIDTH-1:0] freq_q, freq_d;
  logic valid_q, valid_d;
  logic inr_q, inr_d;
  logic lost_q, lost_d;
  logic [PERIOD_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [PERIOD_WIDTH-1:0] per_q, per_d;
  logic seen_q, seen_d;
  logic pv_q, pv_d;
  int   cnt_i;

  // Signed view so the range check never degenerates
  // into an always-true unsigned compare.
  assign cnt_i = int'(ecnt_q);

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= bus.SIG_IN;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      edge_q <= s2_q & ~s3_q;
    end
  end

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    ecnt_d  = ecnt_q;
    freq_d  = freq_q;
    valid_d = 1'b0;
    inr_d   = inr_q;
    lost_d  = lost_q;
    unique case (state_q)
      IDLE: begin
        gate_d = '0;
        ecnt_d = '0;
        if (bus.EN) state_d = ARM;
      end
      ARM: begin
        gate_d  = '0;
        ecnt_d  = '0;
        state_d = bus.EN ? MEASURE : IDLE;
      end
      MEASURE: begin
        gate_d = gate_q + 32'd1;
        if (edge_q && ecnt_q != CNT_MAX)
          ecnt_d = ecnt_q + CNT_WIDTH'(1);
        if (!bus.EN)
          state_d = IDLE;
        else if (gate_q == GATE_LAST)
          state_d = REPORT;
      end
      REPORT: begin
        freq_d  = ecnt_q;
        inr_d   = (cnt_i >= EXP_MIN) &&
                  (cnt_i <= EXP_MAX);
        lost_d  = (ecnt_q == '0);
        valid_d = 1'b1;
        state_d = bus.EN ? ARM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pcnt_d = pcnt_q;
    per_d  = per_q;
    seen_d = seen_q;
    pv_d   = 1'b0;
    if (!bus.EN) begin
      seen_d = 1'b0;
      pcnt_d = '0;
    end else if (edge_q) begin
      pcnt_d = '0;
      seen_d = 1'b1;
      if (seen_q) begin
        pv_d  = 1'b1;
        per_d = (pcnt_q == PER_MAX) ? PER_MAX :
                pcnt_q + PERIOD_WIDTH'(1);
      end
    end else if (pcnt_q != PER_MAX) begin
      pcnt_d = pcnt_q + PERIOD_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gate_q  <= '0;
      ecnt_q  <= '0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      inr_q   <= 1'b0;
      lost_q  <= 1'b0;
      pcnt_q  <= '0;
      per_q   <= '0;
      seen_q  <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      ecnt_q  <= ecnt_d;
      freq_q  <= freq_d;
      valid_q <= valid_d;
      inr_q   <= inr_d;
      lost_q  <= lost_d;
      pcnt_q  <= pcnt_d;
      per_q   <= per_d;
      seen_q  <= seen_d;
      pv_q    <= pv_d;
    end
  end

  assign bus.FREQ_COUNT   = freq_q;
  assign bus.VALID        = valid_q;
  assign bus.IN_RANGE     = inr_q;
  assign bus.CLK_LOST     = lost_q;
  assign bus.PERIOD       = per_q;
  assign bus.PERIOD_VALID = pv_q;
endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: two parameterisations driven with the
// same stimulus and checked every cycle against an event model.
module tb_clk_freq_meter;
  localparam int G = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic sig = 1'b0;
  always #5 clk = ~clk;

  clk_freq_meter_if #(.CNT_WIDTH(16), .PERIOD_WIDTH(16)) ifa ();
  clk_freq_meter_if #(.CNT_WIDTH(4), .PERIOD_WIDTH(8)) ifb ();
  assign ifa.EN = en;
  assign ifa.SIG_IN = sig;
  assign ifb.EN = en;
  assign ifb.SIG_IN = sig;

  clk_freq_meter #(
    .GATE_CYCLES(G), .CNT_WIDTH(16), .PERIOD_WIDTH(16),
    .EXP_MIN(9), .EXP_MAX(11)
  ) dut_a (.CLK_IN(clk), .RST_N(rst_n), .bus(ifa));

  clk_freq_meter #(
    .GATE_CYCLES(G), .CNT_WIDTH(4), .PERIOD_WIDTH(8),
    .EXP_MIN(10), .EXP_MAX(15)
  ) dut_b (.CLK_IN(clk), .RST_N(rst_n), .bus(ifb));

  int af[2], ap[2], av[2], ar[2], al[2], apv[2];
  assign af[0]  = int'(ifa.FREQ_COUNT);
  assign af[1]  = int'(ifb.FREQ_COUNT);
  assign ap[0]  = int'(ifa.PERIOD);
  assign ap[1]  = int'(ifb.PERIOD);
  assign av[0]  = int'(ifa.VALID);
  assign av[1]  = int'(ifb.VALID);
  assign ar[0]  = int'(ifa.IN_RANGE);
  assign ar[1]  = int'(ifb.IN_RANGE);
  assign al[0]  = int'(ifa.CLK_LOST);
  assign al[1]  = int'(ifb.CLK_LOST);
  assign apv[0] = int'(ifa.PERIOD_VALID);
  assign apv[1] = int'(ifb.PERIOD_VALID);

  int CMAX[2] = '{65535, 15};
  int PMAX[2] = '{65535, 255};
  int LO[2]   = '{9, 10};
  int HI[2]   = '{11, 15};

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Stimulus generator: 0 = low, -1 = high, -2 = random
  // segments of 2..20 cycles, >0 = square wave of that period.
  int mode_per = 0;
  int ph = 0;
  int seg = 0;
  always @(negedge clk) begin
    if (mode_per > 0) begin
      sig = (ph < mode_per / 2);
      ph = (ph + 1) % mode_per;
    end else if (mode_per == 0) begin
      sig = 1'b0;
    end else if (mode_per == -1) begin
      sig = 1'b1;
    end else begin
      if (seg <= 0) begin
        sig = ~sig;
        seg = $urandom_range(2, 20);
      end
      seg--;
    end
  end

  // Reference model in terms of edge times: a sampled rise at
  // clock edge k is seen by the counters at edge k+3; a window
  // started at edge t counts edges seen at t+2..t+G+1 and
  // reports at t+G+2.
  int ef[2], ep_[2], ev[2], er[2], el[2], epv[2];
  int k = 0;
  bit prev = 1'b0;
  int rise_q[$];
  bit busy = 1'b0;
  int start = 0;
  int wcnt = 0;
  bit seen = 1'b0;
  int lastk = 0;

  always @(posedge clk or negedge rst_n) begin : mdl
    bit ep;
    int off;
    int f;
    if (!rst_n) begin
      k = 0; prev = 1'b0; rise_q.delete();
      busy = 1'b0; wcnt = 0; seen = 1'b0; lastk = 0;
      for (int d = 0; d < 2; d++) begin
        ef[d] = 0; ep_[d] = 0; ev[d] = 0;
        er[d] = 0; el[d] = 0; epv[d] = 0;
      end
    end else begin
      ep = 1'b0;
      if (rise_q.size() > 0 && rise_q[0] == k) begin
        ep = 1'b1;
        void'(rise_q.pop_front());
      end
      if (sig && !prev) rise_q.push_back(k + 3);
      prev = sig;
      for (int d = 0; d < 2; d++) begin
        ev[d] = 0;
        epv[d] = 0;
      end
      if (!en) begin
        seen = 1'b0;
      end else if (ep) begin
        if (seen)
          for (int d = 0; d < 2; d++) begin
            ep_[d] = (k - lastk > PMAX[d]) ? PMAX[d] : k - lastk;
            epv[d] = 1;
          end
        seen = 1'b1;
        lastk = k;
      end
      if (busy) begin
        off = k - start;
        if (off <= G + 1 && !en) begin
          busy = 1'b0;
        end else if (off <= G + 1) begin
          if (off >= 2 && ep) wcnt++;
        end else begin
          for (int d = 0; d < 2; d++) begin
            f = (wcnt > CMAX[d]) ? CMAX[d] : wcnt;
            ef[d] = f;
            er[d] = (f >= LO[d] && f <= HI[d]) ? 1 : 0;
            el[d] = (f == 0) ? 1 : 0;
            ev[d] = 1;
          end
          busy = 1'b0;
        end
      end
      if (!busy && en) begin
        busy = 1'b1;
        start = k;
        wcnt = 0;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (chk_on)
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (af[d] != ef[d] || av[d] != ev[d] || ar[d] != er[d] ||
            al[d] != el[d] || ap[d] != ep_[d] || apv[d] != epv[d]) begin
          miscompares++;
          $display("FAIL cycle dut%0d @%0t: got f=%0d v=%0d r=%0d l=%0d p=%0d pv=%0d want f=%0d v=%0d r=%0d l=%0d p=%0d pv=%0d",
            d, $time, af[d], av[d], ar[d], al[d], ap[d], apv[d],
            ef[d], ev[d], er[d], el[d], ep_[d], epv[d]);
        end
      end
  end

  typedef struct {
    int per;
    int ncyc;
    int fa; int ra; int la; int pa;
    int fb; int rb; int pb;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int nv;
    int i;
    tbl[0] = '{10,  320, 10, 1, 0, 10,  10, 1, 10};
    tbl[1] = '{0,   320, 0,  0, 1, 10,  0,  0, 10};
    tbl[2] = '{4,   320, 25, 0, 0, 4,   15, 1, 4};
    tbl[3] = '{300, 700, -1, -1, -1, 300, -1, -1, 255};
    tbl[4] = '{20,  320, 5,  0, 0, 20,  5,  0, 20};

    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_freq", af[0], 0);
    chk("reset_valid", av[0], 0);
    chk("reset_period", ap[1], 0);
    chk_on = 1'b1;

    for (int t = 0; t < 5; t++) begin
      en = 1'b0;
      mode_per = tbl[t].per;
      repeat (6) @(negedge clk);
      en = 1'b1;
      repeat (tbl[t].ncyc) @(negedge clk);
      if (tbl[t].fa >= 0) begin
        chk($sformatf("t%0d_freq_a", t), af[0], tbl[t].fa);
        chk($sformatf("t%0d_inr_a", t), ar[0], tbl[t].ra);
        chk($sformatf("t%0d_lost_a", t), al[0], tbl[t].la);
        chk($sformatf("t%0d_freq_b", t), af[1], tbl[t].fb);
        chk($sformatf("t%0d_inr_b", t), ar[1], tbl[t].rb);
      end
      chk($sformatf("t%0d_per_a", t), ap[0], tbl[t].pa);
      chk($sformatf("t%0d_per_b", t), ap[1], tbl[t].pb);
    end

    // Abort mid-window, then re-arm and time the next report.
    en = 1'b0;
    mode_per = 10;
    repeat (6) @(negedge clk);
    en = 1'b1;
    repeat (51) @(negedge clk);
    en = 1'b0;
    nv = 0;
    repeat (150) begin
      @(negedge clk);
      if (av[0] != 0) nv++;
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_hold_freq", af[0], 5);
    en = 1'b1;
    for (i = 0; i <= 300; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (av[0] != 0) break;
    end
    chk("rearm_latency", i, G + 2);
    chk("rearm_freq", af[0], 10);

    // Reset mid-measure with SIG_IN held high.
    mode_per = -1;
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_freq_a", af[0], 0);
    chk("rst_inr_a", ar[0], 0);
    chk("rst_period_a", ap[0], 0);
    chk("rst_valid_b", av[1], 0);
    chk("rst_period_b", ap[1], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    mode_per = 10;
    repeat (250) @(negedge clk);

    // Random waveform with random enable bursts.
    mode_per = -2;
    for (int r = 0; r < 25; r++) begin
      en = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(5, 260)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
